// File: rtl/fx_chan_sequencer.sv
// Stereo gain/mono/bypass sequencer: one shared signed multiplier time-multiplexed
// across left and right channels, with double-buffered effect configuration.
module fx_chan_sequencer #(
  parameter int W         = 16,
  parameter int GAIN_FRAC = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         VALID,
  input  logic [W-1:0] left_in,
  input  logic [W-1:0] right_in,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  output logic [W-1:0] left_out,
  output logic [W-1:0] right_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, DONE} state_t;

  localparam logic [W-1:0] UNITY = W'(1 << GAIN_FRAC);

  state_t state, state_nxt;

  logic [W-1:0] gain_l_sh, gain_r_sh, gain_l_act, gain_r_act;
  logic [1:0]   mode_sh, mode_act;
  logic [W-1:0] op_l, op_r, res_l, res_r;

  logic         accept;
  logic [W-1:0] mono_avg, cap_l, cap_r;
  logic [W-1:0] mul_a, mul_b, mul_res;
  logic signed [2*W-1:0] product, shifted;
  logic         fits;

  assign accept = VALID && (state == IDLE);

  // floor((L+R)/2) computed as (L>>>1)+(R>>>1)+(L0&R0): stays within W bits.
  assign mono_avg = W'($signed(left_in) >>> 1) + W'($signed(right_in) >>> 1)
                  + W'(left_in[0] & right_in[0]);
  assign cap_l    = mode_sh[1] ? mono_avg : left_in;
  assign cap_r    = mode_sh[1] ? mono_avg : right_in;

  // Single shared multiplier, operands steered by state.
  assign mul_a   = (state == MUL_R) ? op_r : op_l;
  assign mul_b   = (state == MUL_R) ? gain_r_act : gain_l_act;
  assign product = $signed(mul_a) * $signed(mul_b);
  assign shifted = product >>> GAIN_FRAC;
  assign fits    = (shifted[2*W-1:W-1] == '0) || (shifted[2*W-1:W-1] == '1);

  always_comb begin
    mul_res = '0;
    if (mode_act[0])
      mul_res = mul_a;
    else if (fits)
      mul_res = shifted[W-1:0];
    else
      mul_res = shifted[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (VALID) state_nxt = MUL_L;
      MUL_L:   state_nxt = MUL_R;
      MUL_R:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
  end

  // Configuration shadow/active registers and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_l_sh  <= UNITY;
      gain_r_sh  <= UNITY;
      mode_sh    <= '0;
      gain_l_act <= UNITY;
      gain_r_act <= UNITY;
      mode_act   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (cfg_we) begin
        unique case (cfg_addr)
          2'd0:    gain_l_sh <= cfg_wdata;
          2'd1:    gain_r_sh <= cfg_wdata;
          2'd2:    mode_sh   <= cfg_wdata[1:0];
          default: ;
        endcase
      end
      if (accept) begin
        gain_l_act <= gain_l_sh;
        gain_r_act <= gain_r_sh;
        mode_act   <= mode_sh;
      end
      if (VALID && (state != IDLE))
        overrun <= 1'b1;
      else if (cfg_we && (cfg_addr == 2'd3))
        overrun <= 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_l      <= '0;
      op_r      <= '0;
      res_l     <= '0;
      res_r     <= '0;
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        op_l <= cap_l;
        op_r <= cap_r;
      end
      if (state == MUL_L) res_l <= mul_res;
      if (state == MUL_R) res_r <= mul_res;
      if (state == DONE) begin
        left_out  <= res_l;
        right_out <= res_r;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fx_chan_sequencer.sv
// Self-checking bench for fx_chan_sequencer: directed table, corner sequences,
// and randomized samples against an arithmetic reference model.
module tb_fx_chan_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         VALID = 1'b0;
  logic [W-1:0] left_in = '0, right_in = '0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [W-1:0] cfg_wdata = '0;
  logic [W-1:0] left_out, right_out;
  logic         out_valid, busy, overrun;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] m_gl, m_gr;
  logic [1:0]  m_mode;

  always #5 clk = ~clk;

  fx_chan_sequencer #(.W(W), .GAIN_FRAC(14)) dut (
    .clk(clk), .rst(rst), .VALID(VALID), .left_in(left_in), .right_in(right_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: gain as real-valued Q2.14 multiply, floor, clamp to 16-bit range.
  function automatic logic [15:0] mdl_chan(input logic [15:0] x, input logic [15:0] g,
                                           input bit byp);
    shortint xs, gs;
    longint  p, q;
    xs = x;
    gs = g;
    if (byp) return x;
    p = longint'(xs) * longint'(gs);
    q = p / 16384;
    if (p < 0 && (p % 16384) != 0) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [15:0] mdl_mono(input logic [15:0] l, input logic [15:0] r);
    shortint ls, rs;
    longint  s, m;
    ls = l;
    rs = r;
    s = longint'(ls) + longint'(rs);
    m = s / 2;
    if (s < 0 && (s % 2) != 0) m = m - 1;
    return m[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; VALID = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_gl = 16'h4000; m_gr = 16'h4000; m_mode = 2'b00;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    case (a)
      2'd0: m_gl = d;
      2'd1: m_gr = d;
      2'd2: m_mode = d[1:0];
      default: ;
    endcase
  endtask

  // One legal sample; checks latency and busy profile over the four following cycles.
  task automatic run_sample(input logic [15:0] l, input logic [15:0] r, input string tag,
                            output logic [15:0] ol, output logic [15:0] orr);
    logic [3:0] ov, bz;
    @(negedge clk);
    VALID = 1'b1; left_in = l; right_in = r;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      VALID = 1'b0;
      ov[i] = out_valid;
      bz[i] = busy;
    end
    check({tag, "_ovalid_timing"}, 32'(ov), 32'h8);
    check({tag, "_busy_profile"}, 32'(bz), 32'h7);
    ol = left_out;
    orr = right_out;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] gl, gr;
    logic [1:0]  mode;
    logic [15:0] l, r, el, er;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] ol, orr, el, er, opl, opr;
    int pulses;

    tbl[0] = '{1'b0, 16'h4000, 16'h4000, 2'b00, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
    tbl[1] = '{1'b1, 16'h2000, 16'h2000, 2'b00, 16'h0003, 16'hFFFD, 16'h0001, 16'hFFFE};
    tbl[2] = '{1'b1, 16'h8000, 16'h7FFF, 2'b00, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{1'b1, 16'h4000, 16'h4000, 2'b10, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[4] = '{1'b1, 16'h4000, 16'h4000, 2'b10, 16'h0004, 16'hFFFA, 16'hFFFF, 16'hFFFF};
    tbl[5] = '{1'b1, 16'h2000, 16'h8000, 2'b01, 16'h1234, 16'h8001, 16'h1234, 16'h8001};
    tbl[6] = '{1'b1, 16'h2000, 16'h2000, 2'b11, 16'h0004, 16'hFFFA, 16'hFFFF, 16'hFFFF};
    tbl[7] = '{1'b1, 16'h7FFF, 16'hC000, 2'b00, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};

    do_reset();
    check("rst_left_out", 32'(left_out), 32'h0);
    check("rst_right_out", 32'(right_out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        cfg_write(2'd0, tbl[i].gl);
        cfg_write(2'd1, tbl[i].gr);
        cfg_write(2'd2, {14'h3FFC, tbl[i].mode});
      end
      run_sample(tbl[i].l, tbl[i].r, $sformatf("tbl%0d", i), ol, orr);
      check($sformatf("tbl%0d_left", i), 32'(ol), 32'(tbl[i].el));
      check($sformatf("tbl%0d_right", i), 32'(orr), 32'(tbl[i].er));
    end

    // Overrun: second VALID two edges after acceptance is dropped.
    do_reset();
    @(negedge clk); VALID = 1'b1; left_in = 16'h0111; right_in = 16'h0222;
    @(negedge clk); VALID = 1'b0;
    @(negedge clk); VALID = 1'b1; left_in = 16'h7777; right_in = 16'h6666;
    @(negedge clk); VALID = 1'b0;
    pulses = 0; ol = '0; orr = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin pulses++; ol = left_out; orr = right_out; end
      @(negedge clk);
    end
    check("ovr_pulses", 32'(pulses), 32'd1);
    check("ovr_left", 32'(ol), 32'h0111);
    check("ovr_right", 32'(orr), 32'h0222);
    check("ovr_flag_set", 32'(overrun), 32'h1);

    // Clear coinciding with a new overrun: set wins.
    @(negedge clk); VALID = 1'b1; left_in = 16'h0005; right_in = 16'h0005;
    @(negedge clk); VALID = 1'b0;
    @(negedge clk); VALID = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 16'hFFFF;
    @(negedge clk); VALID = 1'b0; cfg_we = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'h1);
    repeat (4) @(negedge clk);
    cfg_write(2'd3, 16'h1234);
    check("ovr_cleared", 32'(overrun), 32'h0);
    run_sample(16'h0100, 16'h0100, "post_clear", ol, orr);
    check("post_clear_gain_l", 32'(ol), 32'h0100);

    // Config write on the accepting edge applies only to the next sample.
    do_reset();
    @(negedge clk);
    VALID = 1'b1; left_in = 16'h0100; right_in = 16'h0100;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'h2000;
    @(negedge clk); VALID = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("bnd_ovalid", 32'(out_valid), 32'h1);
    check("bnd_old_gain", 32'(left_out), 32'h0100);
    m_gl = 16'h2000;
    run_sample(16'h0100, 16'h0100, "bnd_next", ol, orr);
    check("bnd_new_gain_l", 32'(ol), 32'h0080);
    check("bnd_new_gain_r", 32'(orr), 32'h0100);

    // Reset asserted while in MUL_R abandons the sample.
    @(negedge clk); VALID = 1'b1; left_in = 16'h1111; right_in = 16'h2222;
    @(negedge clk); VALID = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("midrst_pulses", 32'(pulses), 32'd0);
    check("midrst_left", 32'(left_out), 32'h0);
    check("midrst_right", 32'(right_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    m_gl = 16'h4000; m_gr = 16'h4000; m_mode = 2'b00;

    // Randomized samples against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] pick [5];
      logic [15:0] l, r;
      pick[0] = 16'h8000; pick[1] = 16'h7FFF; pick[2] = 16'h0000; pick[3] = 16'hFFFF;
      pick[4] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) cfg_write(2'd0, 16'($urandom));
      if ($urandom_range(0, 2) == 0) cfg_write(2'd1, 16'($urandom));
      if ($urandom_range(0, 3) == 0) cfg_write(2'd2, 16'($urandom));
      l = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
      r = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 16'($urandom);
      opl = m_mode[1] ? mdl_mono(l, r) : l;
      opr = m_mode[1] ? mdl_mono(l, r) : r;
      el = mdl_chan(opl, m_gl, m_mode[0]);
      er = mdl_chan(opr, m_gr, m_mode[0]);
      run_sample(l, r, $sformatf("rnd%0d", k), ol, orr);
      check($sformatf("rnd%0d_left", k), 32'(ol), 32'(el));
      check($sformatf("rnd%0d_right", k), 32'(orr), 32'(er));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
